// File: rtl/priority_arbiter_seq_if.sv
// Handshake bundle between requesters and priority_arbiter_seq.
// The master side drives requests, priorities and the acknowledge;
// the slave side (the arbiter) returns the registered grant.
interface priority_arbiter_seq_if #(
   parameter int N         = 8,
   parameter int PRIO_BITS = 3,
   parameter int SEL_W     = $clog2(N)
);
   logic [N-1:0]           req_i;
   logic [N*PRIO_BITS-1:0] prio_i;
   logic                   ack_i;
   logic [N-1:0]           gnt_o;
   logic                   gnt_valid_o;
   logic [SEL_W-1:0]       sel_o;
   logic [PRIO_BITS-1:0]   prio_o;
   logic                   preempt_o;

   modport master (
      output req_i, prio_i, ack_i,
      input  gnt_o, gnt_valid_o, sel_o, prio_o, preempt_o
   );

   modport slave (
      input  req_i, prio_i, ack_i,
      output gnt_o, gnt_valid_o, sel_o, prio_o, preempt_o
   );
endinterface

// File: rtl/priority_arbiter_seq.sv
// Registered, lockable N-way priority arbiter.
// The active request with the lowest prio value wins and keeps the grant
// until it acknowledges, drops its request, or is preempted after MAX_HOLD
// cycles while someone else waits (MAX_HOLD = 0 disables preemption).
// Optional feature macro PRIO_ARB_RR_EN: equal-priority ties rotate
// round-robin after the last holder; otherwise ties go to the lowest index.
module priority_arbiter_seq #(
   parameter int N         = 8,
   parameter int PRIO_BITS = 3,
   parameter int SEL_W     = $clog2(N),
   parameter int MAX_HOLD  = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   priority_arbiter_seq_if.slave arb
);

   localparam int CNT_W = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] GRANT = 1'b1;

   // Registered state and outputs
   logic [0:0]           state,     state_n;
   logic [CNT_W-1:0]     hold_cnt,  hold_n;
   logic [N-1:0]         gnt_q,     gnt_n;
   logic                 valid_q,   valid_n;
   logic [SEL_W-1:0]     sel_q,     sel_n;
   logic [PRIO_BITS-1:0] prio_q,    prio_n;
   logic                 preempt_q, preempt_n;
`ifdef PRIO_ARB_RR_EN
   logic [SEL_W-1:0]     rr_ptr,    rr_ptr_n;
`endif

   // Arbitration helpers
   logic [PRIO_BITS-1:0] prio_arr [N];
   logic [N-1:0]         arb_req;
   logic                 holder_req;
   logic                 others_req;
   logic                 release_ab;
   logic                 timeout;
   logic                 grant_now;
   logic                 win_found;
   logic [SEL_W-1:0]     win_idx;
   logic [PRIO_BITS-1:0] win_prio;

   for (genvar g = 0; g < N; g++) begin : g_prio
      assign prio_arr[g] = arb.prio_i[g*PRIO_BITS +: PRIO_BITS];
   end

   // The holder is released by ack or by abandoning its request; a timeout
   // applies only when the holder stays and somebody else is waiting.
   assign holder_req = arb.req_i[sel_q];
   assign others_req = |(arb.req_i & ~gnt_q);
   assign release_ab = arb.ack_i || !holder_req;
   assign timeout    = (state == GRANT) && (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)
                       && others_req && !release_ab;
   assign arb_req    = timeout ? (arb.req_i & ~gnt_q) : arb.req_i;

   // Winner search: lowest prio value, first candidate in scan order wins ties
   always_comb begin : winner_sel
      int               idx;
      logic [SEL_W-1:0] idx_s;
      idx       = 0;
      idx_s     = '0;
      win_found = 1'b0;
      win_idx   = '0;
      win_prio  = '0;
      for (int k = 1; k <= N; k++) begin
`ifdef PRIO_ARB_RR_EN
         // Scan starts just after the last holder and wraps N-1 -> 0
         idx = int'(rr_ptr) + k;
         if (idx >= N) idx = idx - N;
`else
         idx = k - 1;
`endif
         idx_s = SEL_W'(idx);
         if (arb_req[idx_s] && (!win_found || prio_arr[idx_s] < win_prio)) begin
            win_found = 1'b1;
            win_idx   = idx_s;
            win_prio  = prio_arr[idx_s];
         end
      end
   end

   // Next-state logic for the IDLE/GRANT controller and its outputs
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      state_n   = state;
      hold_n    = hold_cnt;
      gnt_n     = gnt_q;
      valid_n   = valid_q;
      sel_n     = sel_q;
      prio_n    = prio_q;
      preempt_n = 1'b0;
`ifdef PRIO_ARB_RR_EN
      rr_ptr_n  = rr_ptr;
`endif
      grant_now = 1'b0;

      case (state)
         IDLE: begin
            grant_now = win_found;
         end
         GRANT: begin
            if (release_ab || timeout) begin
               if (win_found) begin
                  grant_now = 1'b1;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  valid_n = 1'b0;
                  hold_n  = '0;
               end
            end else if ((MAX_HOLD != 0) && (hold_cnt != HOLD_LAST)) begin
               hold_n = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      if (grant_now) begin
         state_n        = GRANT;
         gnt_n          = '0;
         gnt_n[win_idx] = 1'b1;
         valid_n        = 1'b1;
         sel_n          = win_idx;
         prio_n         = win_prio;
         hold_n         = '0;
         preempt_n      = timeout;
`ifdef PRIO_ARB_RR_EN
         rr_ptr_n       = win_idx;
`endif
      end
   end

   // State register with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         state     <= IDLE;
         hold_cnt  <= '0;
         gnt_q     <= '0;
         valid_q   <= 1'b0;
         sel_q     <= '0;
         prio_q    <= '0;
         preempt_q <= 1'b0;
`ifdef PRIO_ARB_RR_EN
         rr_ptr    <= SEL_W'(N - 1);
`endif
      end else begin
         state     <= state_n;
         hold_cnt  <= hold_n;
         gnt_q     <= gnt_n;
         valid_q   <= valid_n;
         sel_q     <= sel_n;
         prio_q    <= prio_n;
         preempt_q <= preempt_n;
`ifdef PRIO_ARB_RR_EN
         rr_ptr    <= rr_ptr_n;
`endif
      end
   end

   assign arb.gnt_o       = gnt_q;
   assign arb.gnt_valid_o = valid_q;
   assign arb.sel_o       = sel_q;
   assign arb.prio_o      = prio_q;
   assign arb.preempt_o   = preempt_q;

endmodule

// File: tb/tb_priority_arbiter_seq.sv
// Directed testbench for priority_arbiter_seq (N=8, PRIO_BITS=3, MAX_HOLD=4).
// Expected output tuples are hand-computed from the arbiter's rules.
// Tie-break expectations follow PRIO_ARB_RR_EN when it is defined.
module tb_priority_arbiter_seq;

   typedef struct packed {
      logic       valid;
      logic       preempt;
      logic [7:0] gnt;
      logic [2:0] sel;
      logic [2:0] prio;
   } out_t;

   logic clk;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;
   out_t obs;
   out_t exp_o;

   priority_arbiter_seq_if #(.N(8), .PRIO_BITS(3)) bus ();

   priority_arbiter_seq #(
      .N        (8),
      .PRIO_BITS(3),
      .MAX_HOLD (4)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .arb  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {bus.gnt_valid_o, bus.preempt_o, bus.gnt_o, bus.sel_o, bus.prio_o};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   function automatic out_t mk(input logic v, input logic p, input logic [7:0] g,
                               input logic [2:0] s, input logic [2:0] pr);
      return {v, p, g, s, pr};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      bus.req_i  = '0;
      bus.ack_i  = 1'b0;
      step();
      rst        = 1'b0;
   endtask

   task automatic test_reset();
      rst        = 1'b1;
      bus.req_i  = 8'hFF;
      bus.prio_i = '0;
      bus.ack_i  = 1'b0;
      step();
      step();
      exp_o = mk(1'b0, 1'b0, 8'h00, 3'd0, 3'd0);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL reset_values: got %p want %p", obs, exp_o);
      end
      // ack while idle must not create a grant
      rst       = 1'b0;
      bus.req_i = '0;
      bus.ack_i = 1'b1;
      step();
      vectors++;
      if ({obs.valid, obs.preempt, obs.gnt} !== 10'b0) begin
         miscompares++;
         $display("FAIL idle_ack_ignored: got %p want idle", obs);
      end
      bus.ack_i = 1'b0;
   endtask

   task automatic test_basic_grant();
      do_reset();
      // fields [7..0] = {1,2,3,4,0,5,6,7}
      bus.prio_i = {3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd5, 3'd6, 3'd7};
      bus.req_i  = 8'b1101_1011;
      #1;
      vectors++;
      if (obs.valid !== 1'b0) begin
         miscompares++;
         $display("FAIL grant_not_early: got valid=%0b want 0", obs.valid);
      end
      step();
      exp_o = mk(1'b1, 1'b0, 8'h08, 3'd3, 3'd0);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL basic_grant: got %p want %p", obs, exp_o);
      end
   endtask

   task automatic test_back_to_back();
      // holder 3 acks with request still up: wins again, no bubble
      bus.ack_i = 1'b1;
      step();
      exp_o = mk(1'b1, 1'b0, 8'h08, 3'd3, 3'd0);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL b2b_regrant: got %p want %p", obs, exp_o);
      end
      // req[3] dropped at the ack: requester 7 (prio 1) is next best
      bus.req_i = 8'b1101_0011;
      step();
      exp_o = mk(1'b1, 1'b0, 8'h80, 3'd7, 3'd1);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL b2b_next7: got %p want %p", obs, exp_o);
      end
      // only 4,1,0 left: requester 4 (prio 4)
      bus.req_i = 8'b0001_0011;
      step();
      exp_o = mk(1'b1, 1'b0, 8'h10, 3'd4, 3'd4);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL b2b_next4: got %p want %p", obs, exp_o);
      end
      bus.ack_i = 1'b0;
      bus.req_i = '0;
      step();
      vectors++;
      if ({obs.valid, obs.preempt, obs.gnt} !== 10'b0) begin
         miscompares++;
         $display("FAIL b2b_to_idle: got %p want idle", obs);
      end
   endtask

   task automatic test_ties();
      logic [2:0] want;
      do_reset();
      bus.prio_i = 24'o22222222;
      bus.req_i  = 8'hFF;
      bus.ack_i  = 1'b1;
      for (int i = 0; i < 9; i++) begin
         step();
`ifdef PRIO_ARB_RR_EN
         want = 3'(i % 8);
`else
         want = 3'd0;
`endif
         exp_o = mk(1'b1, 1'b0, 8'(1) << want, want, 3'd2);
         vectors++;
         if (obs !== exp_o) begin
            miscompares++;
            $display("FAIL tie_grant_%0d: got %p want %p", i, obs, exp_o);
         end
      end
      bus.ack_i = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      bus.prio_i = {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd1, 3'd0};
      bus.req_i  = 8'h03;
      for (int i = 0; i < 4; i++) begin
         step();
         exp_o = mk(1'b1, 1'b0, 8'h01, 3'd0, 3'd0);
         vectors++;
         if (obs !== exp_o) begin
            miscompares++;
            $display("FAIL hold0_cycle%0d: got %p want %p", i, obs, exp_o);
         end
      end
      step();
      exp_o = mk(1'b1, 1'b1, 8'h02, 3'd1, 3'd1);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL preempt_to1: got %p want %p", obs, exp_o);
      end
      step();
      exp_o = mk(1'b1, 1'b0, 8'h02, 3'd1, 3'd1);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL preempt_pulse_end: got %p want %p", obs, exp_o);
      end
      step();
      step();
      step();
      exp_o = mk(1'b1, 1'b1, 8'h01, 3'd0, 3'd0);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL preempt_back0: got %p want %p", obs, exp_o);
      end
   endtask

   task automatic test_lone_holder();
      do_reset();
      bus.prio_i = {3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7, 3'd1, 3'd0};
      bus.req_i  = 8'h01;
      step();
      for (int i = 0; i < 8; i++) begin
         step();
         exp_o = mk(1'b1, 1'b0, 8'h01, 3'd0, 3'd0);
         vectors++;
         if (obs !== exp_o) begin
            miscompares++;
            $display("FAIL lone_hold_%0d: got %p want %p", i, obs, exp_o);
         end
      end
      // counter is saturated, so a newcomer preempts at the very next edge
      bus.req_i = 8'h03;
      step();
      exp_o = mk(1'b1, 1'b1, 8'h02, 3'd1, 3'd1);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL saturated_preempt: got %p want %p", obs, exp_o);
      end
   endtask

   task automatic test_prio_change();
      do_reset();
      bus.prio_i = 24'd5;
      bus.req_i  = 8'h01;
      step();
      bus.prio_i = 24'd2;
      step();
      exp_o = mk(1'b1, 1'b0, 8'h01, 3'd0, 3'd5);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL prio_latched: got %p want %p", obs, exp_o);
      end
      bus.ack_i = 1'b1;
      step();
      exp_o = mk(1'b1, 1'b0, 8'h01, 3'd0, 3'd2);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL prio_rearb: got %p want %p", obs, exp_o);
      end
      bus.ack_i = 1'b0;
   endtask

   task automatic test_abandon();
      do_reset();
      bus.prio_i = '0;
      bus.req_i  = 8'h04;
      step();
      exp_o = mk(1'b1, 1'b0, 8'h04, 3'd2, 3'd0);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL abandon_grant: got %p want %p", obs, exp_o);
      end
      bus.req_i = '0;
      step();
      vectors++;
      if ({obs.valid, obs.preempt, obs.gnt} !== 10'b0) begin
         miscompares++;
         $display("FAIL abandon_idle: got %p want idle", obs);
      end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      // field3 = 1, field2 = 3
      bus.prio_i = 24'h0002C0;
      bus.req_i  = 8'h0C;
      step();
      exp_o = mk(1'b1, 1'b0, 8'h08, 3'd3, 3'd1);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL pre_reset_grant: got %p want %p", obs, exp_o);
      end
      rst = 1'b1;
      step();
      exp_o = mk(1'b0, 1'b0, 8'h00, 3'd0, 3'd0);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL mid_grant_reset: got %p want %p", obs, exp_o);
      end
      rst = 1'b0;
      step();
      exp_o = mk(1'b1, 1'b0, 8'h08, 3'd3, 3'd1);
      vectors++;
      if (obs !== exp_o) begin
         miscompares++;
         $display("FAIL post_reset_regrant: got %p want %p", obs, exp_o);
      end
   endtask

   initial begin
      rst        = 1'b1;
      bus.req_i  = '0;
      bus.prio_i = '0;
      bus.ack_i  = 1'b0;
      test_reset();
      test_basic_grant();
      test_back_to_back();
      test_ties();
      test_timeout();
      test_lone_holder();
      test_prio_change();
      test_abandon();
      test_reset_mid_grant();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
